// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer for a 6502-style decoder: fetches opcode and operand bytes at PC,
// holds them for the decoder until instruction_done, then advances or reloads PC. Has a stall watchdog.
module fetch_sequencer #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    REG_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'h0600,
    parameter int                    TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [REG_WIDTH-1:0]  mem_rdata,
    input  logic                  mem_ack,
    output logic [REG_WIDTH-1:0]  instruction,
    output logic [ADDR_WIDTH-1:0] operand,
    output logic                  instruction_ready,
    input  logic                  instruction_done,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_val,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  halted,
    output logic [2:0]            fsm_state
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        FETCH_OP = 3'd0,
        FETCH_LO = 3'd1,
        FETCH_HI = 3'd2,
        EXEC     = 3'd3,
        HALT     = 3'd4
    } state_t;

    // Handshakes: mem_rd is a request held with a stable mem_addr until mem_ack is seen high at a
    // rising edge (mem_ack while mem_rd=0 is ignored); instruction_ready is a level held until the
    // decoder pulses instruction_done, which is only honoured in EXEC.

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   pc_next, mem_addr_next, operand_next, pc_inc;
    logic [REG_WIDTH-1:0]    instruction_next;
    logic                    mem_rd_next, ready_next, halted_next, enter_exec;
    logic [WD_W-1:0]         watchdog, watchdog_next;
    logic [1:0]              nbytes, nbytes_next, op_bytes;

    function automatic logic [1:0] nbytes_of(input logic [REG_WIDTH-1:0] op);
        logic [1:0] n;
        if (op[4:2] == 3'b011 || op[4:2] == 3'b110 || op[4:2] == 3'b111)
            n = 2'd2;
        else if (op[1:0] == 2'b10 && op[4:2] == 3'b010)
            n = 2'd0;
        else
            n = 2'd1;
        return n;
    endfunction

    assign pc_inc    = pc + ADDR_WIDTH'(1);
    assign op_bytes  = nbytes_of(mem_rdata);
    assign fsm_state = state;

    always_comb begin
        state_next       = state;
        pc_next          = pc;
        mem_rd_next      = mem_rd;
        mem_addr_next    = mem_addr;
        instruction_next = instruction;
        operand_next     = operand;
        ready_next       = instruction_ready;
        halted_next      = halted;
        watchdog_next    = watchdog;
        nbytes_next      = nbytes;
        enter_exec       = 1'b0;

        case (state)
            FETCH_OP: begin
                if (mem_rd) begin
                    if (mem_ack) begin
                        instruction_next = mem_rdata;
                        operand_next     = '0;
                        pc_next          = pc_inc;
                        nbytes_next      = op_bytes;
                        if (op_bytes == 2'd0) begin
                            enter_exec = 1'b1;
                        end else begin
                            // Keep mem_rd high so operand bytes stream back-to-back.
                            state_next    = FETCH_LO;
                            mem_addr_next = pc_inc;
                        end
                    end
                end else if (run) begin
                    mem_rd_next   = 1'b1;
                    mem_addr_next = pc;
                end
            end
            FETCH_LO: begin
                if (mem_rd && mem_ack) begin
                    operand_next[REG_WIDTH-1:0] = mem_rdata;
                    pc_next                     = pc_inc;
                    if (nbytes == 2'd2) begin
                        state_next    = FETCH_HI;
                        mem_addr_next = pc_inc;
                    end else begin
                        enter_exec = 1'b1;
                    end
                end
            end
            FETCH_HI: begin
                if (mem_rd && mem_ack) begin
                    operand_next[2*REG_WIDTH-1:REG_WIDTH] = mem_rdata;
                    pc_next                               = pc_inc;
                    enter_exec                            = 1'b1;
                end
            end
            EXEC: begin
                // A done arriving on the final watchdog cycle still completes normally.
                if (instruction_done) begin
                    ready_next = 1'b0;
                    state_next = FETCH_OP;
                    if (pc_load)
                        pc_next = pc_load_val;
                end else if (watchdog == WD_W'(TIMEOUT - 1)) begin
                    state_next  = HALT;
                    halted_next = 1'b1;
                    ready_next  = 1'b0;
                end else begin
                    watchdog_next = watchdog + WD_W'(1);
                end
            end
            HALT: begin
                mem_rd_next = 1'b0;
                ready_next  = 1'b0;
                halted_next = 1'b1;
            end
            default: state_next = FETCH_OP;
        endcase

        if (enter_exec) begin
            state_next    = EXEC;
            mem_rd_next   = 1'b0;
            ready_next    = 1'b1;
            watchdog_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= FETCH_OP;
            pc                <= RESET_PC;
            mem_rd            <= 1'b0;
            mem_addr          <= '0;
            instruction       <= '0;
            operand           <= '0;
            instruction_ready <= 1'b0;
            halted            <= 1'b0;
            watchdog          <= '0;
            nbytes            <= 2'd0;
        end else begin
            state             <= state_next;
            pc                <= pc_next;
            mem_rd            <= mem_rd_next;
            mem_addr          <= mem_addr_next;
            instruction       <= instruction_next;
            operand           <= operand_next;
            instruction_ready <= ready_next;
            halted            <= halted_next;
            watchdog          <= watchdog_next;
            nbytes            <= nbytes_next;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a byte-array memory answers reads, the bench plays decoder.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset_n;
    logic        run;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [7:0]  instruction;
    logic [15:0] operand;
    logic        instruction_ready;
    logic        instruction_done;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic [15:0] pc;
    logic        halted;
    logic [2:0]  fsm_state;

    logic [7:0]  mem [0:65535];
    bit          ack_hold;
    int          checks;
    int          errors;
    int          read_count;
    int          r0;
    int          lat;

    fetch_sequencer dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .run               (run),
        .mem_addr          (mem_addr),
        .mem_rd            (mem_rd),
        .mem_rdata         (mem_rdata),
        .mem_ack           (mem_ack),
        .instruction       (instruction),
        .operand           (operand),
        .instruction_ready (instruction_ready),
        .instruction_done  (instruction_done),
        .pc_load           (pc_load),
        .pc_load_val       (pc_load_val),
        .pc                (pc),
        .halted            (halted),
        .fsm_state         (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory answers any pending read before the next rising edge unless held off
    always @(negedge clk) begin
        mem_ack   = mem_rd && !ack_hold;
        mem_rdata = mem[mem_addr];
    end

    always @(posedge clk) begin
        if (reset_n && mem_rd && mem_ack)
            read_count++;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // lat counts cycles from the first cycle mem_rd is seen up to and including the ready cycle
    task automatic wait_ready(output int l);
        l = 0;
        for (int i = 0; i < 20; i++) begin
            if (instruction_ready) break;
            if (mem_rd || l > 0) l++;
            tick();
        end
        if (instruction_ready) l++;
        check("ready_seen", {31'd0, instruction_ready}, 32'd1);
    endtask

    task automatic finish_instr(input logic load, input logic [15:0] val);
        instruction_done = 1'b1;
        pc_load          = load;
        pc_load_val      = val;
        tick();
        instruction_done = 1'b0;
        pc_load          = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; read_count = 0; ack_hold = 1'b0;
        reset_n = 1'b0; run = 1'b0; instruction_done = 1'b0; pc_load = 1'b0; pc_load_val = 16'h0;
        mem_ack = 1'b0; mem_rdata = 8'h00;
        for (int a = 0; a < 65536; a++) mem[a] = 8'hEA;
        mem[16'h0600] = 8'hA9; mem[16'h0601] = 8'h42;
        mem[16'h0602] = 8'h6D; mem[16'h0603] = 8'h34; mem[16'h0604] = 8'h12;
        mem[16'h0605] = 8'h0A;
        mem[16'hC000] = 8'h4C; mem[16'hC001] = 8'hFE; mem[16'hC002] = 8'hFF;
        mem[16'hFFFE] = 8'hAD; mem[16'hFFFF] = 8'h00; mem[16'h0000] = 8'h80;

        repeat (3) tick();
        check("rst_pc", {16'd0, pc}, 32'h0600);
        check("rst_rd", {31'd0, mem_rd}, 32'd0);
        check("rst_addr", {16'd0, mem_addr}, 32'h0000);
        check("rst_instr", {24'd0, instruction}, 32'h00);
        check("rst_operand", {16'd0, operand}, 32'h0000);
        check("rst_ready", {31'd0, instruction_ready}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_state", {29'd0, fsm_state}, 32'd0);

        // run=0 keeps the sequencer idle
        reset_n = 1'b1;
        repeat (3) tick();
        check("idle_rd", {31'd0, mem_rd}, 32'd0);

        // LDA #$42
        r0 = read_count;
        run = 1'b1;
        tick();
        check("t1_rd", {31'd0, mem_rd}, 32'd1);
        check("t1_addr", {16'd0, mem_addr}, 32'h0600);
        wait_ready(lat);
        check("t1_lat", lat, 32'd3);
        check("t1_reads", read_count - r0, 32'd2);
        check("t1_instr", {24'd0, instruction}, 32'hA9);
        check("t1_operand", {16'd0, operand}, 32'h0042);
        finish_instr(1'b0, 16'h0000);
        check("t1_ready_drop", {31'd0, instruction_ready}, 32'd0);
        check("t1_pc", {16'd0, pc}, 32'h0602);

        // ADC $1234: three reads, ready in the fourth cycle from the first request
        r0 = read_count;
        wait_ready(lat);
        check("t2_lat", lat, 32'd4);
        check("t2_reads", read_count - r0, 32'd3);
        check("t2_instr", {24'd0, instruction}, 32'h6D);
        check("t2_operand", {16'd0, operand}, 32'h1234);
        finish_instr(1'b0, 16'h0000);
        check("t2_pc", {16'd0, pc}, 32'h0605);

        // ASL A: no operand bytes, stale operand cleared
        r0 = read_count;
        wait_ready(lat);
        check("t3_reads", read_count - r0, 32'd1);
        check("t3_instr", {24'd0, instruction}, 32'h0A);
        check("t3_operand", {16'd0, operand}, 32'h0000);
        pc_load = 1'b1; pc_load_val = 16'hC000;
        tick();
        pc_load = 1'b0;
        check("t4_load_no_done", {16'd0, pc}, 32'h0606);
        check("t4_ready_held", {31'd0, instruction_ready}, 32'd1);
        finish_instr(1'b1, 16'hC000);
        check("t4_pc_loaded", {16'd0, pc}, 32'hC000);
        tick();
        check("t4_addr", {16'd0, mem_addr}, 32'hC000);

        // JMP $FFFE, then a 3-byte fetch that wraps through $FFFF
        wait_ready(lat);
        check("t4_instr", {24'd0, instruction}, 32'h4C);
        check("t4_operand", {16'd0, operand}, 32'hFFFE);
        run = 1'b0;
        finish_instr(1'b1, 16'hFFFE);
        repeat (4) tick();
        check("pause_rd", {31'd0, mem_rd}, 32'd0);
        check("pause_pc", {16'd0, pc}, 32'hFFFE);
        run = 1'b1;
        r0 = read_count;
        wait_ready(lat);
        check("t5_reads", read_count - r0, 32'd3);
        check("t5_operand", {16'd0, operand}, 32'h8000);
        check("t5_pc", {16'd0, pc}, 32'h0001);
        finish_instr(1'b0, 16'h0000);

        // done on the last watchdog cycle wins over the timeout
        wait_ready(lat);
        check("wd_instr", {24'd0, instruction}, 32'hEA);
        repeat (63) tick();
        check("wd_edge_halted", {31'd0, halted}, 32'd0);
        finish_instr(1'b0, 16'h0000);
        check("wd_done_wins", {31'd0, halted}, 32'd0);
        check("wd_state", {29'd0, fsm_state}, 32'd0);
        check("wd_pc", {16'd0, pc}, 32'h0002);

        // no done: halt after TIMEOUT cycles in EXEC
        wait_ready(lat);
        repeat (63) tick();
        check("t6_not_yet", {31'd0, halted}, 32'd0);
        tick();
        check("t6_halted", {31'd0, halted}, 32'd1);
        check("t6_ready", {31'd0, instruction_ready}, 32'd0);
        check("t6_state", {29'd0, fsm_state}, 32'd4);
        instruction_done = 1'b1; pc_load = 1'b1; pc_load_val = 16'h0600;
        repeat (5) tick();
        instruction_done = 1'b0; pc_load = 1'b0;
        check("t6_sticky", {31'd0, halted}, 32'd1);
        check("t6_rd", {31'd0, mem_rd}, 32'd0);
        check("t6_pc", {16'd0, pc}, 32'h0003);

        // reset aborts a stalled operand read without waiting for a clock
        reset_n = 1'b0;
        tick();
        check("t7_halt_cleared", {31'd0, halted}, 32'd0);
        reset_n = 1'b1;
        tick();
        tick();
        ack_hold = 1'b1;
        repeat (3) tick();
        check("t7_state_lo", {29'd0, fsm_state}, 32'd1);
        check("t7_rd_held", {31'd0, mem_rd}, 32'd1);
        check("t7_addr", {16'd0, mem_addr}, 32'h0601);
        #2;
        reset_n = 1'b0;
        #1;
        check("t7_pc", {16'd0, pc}, 32'h0600);
        check("t7_rd", {31'd0, mem_rd}, 32'd0);
        check("t7_addr0", {16'd0, mem_addr}, 32'h0000);
        check("t7_instr", {24'd0, instruction}, 32'h00);
        check("t7_state", {29'd0, fsm_state}, 32'd0);

        // report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
